sync_fifo_param: RTL and testbench

//  Single-clock, parametrised successor of our 8-bit x 64 buffer FIFO.

---
 rtl/sync_fifo_param_if.sv | 35 +++
 rtl/sync_fifo_param.sv | 106 ++++++++++
 tb/tb_sync_fifo_param.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param.
// Producer/consumer side uses master; the FIFO uses slave.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic [WIDTH-1:0] buf_in;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] buf_out;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    counter;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, buf_in, wr_en, rd_en,
    input  buf_out, empty, full,
    input  almost_empty, almost_full,
    input  counter, overflow, underflow
  );

  modport slave (
    input  flush, buf_in, wr_en, rd_en,
    output buf_out, empty, full,
    output almost_empty, almost_full,
    output counter, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered flags,
// optional FWFT output, flush and sticky error flags.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 64,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4,
  parameter bit FWFT      = 1'b0
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] buf_q;
  logic             empty_q;
  logic             full_q;
  logic             ae_q;
  logic             af_q;
  logic             ovf_q;
  logic             unf_q;
  logic             rd_ok;
  logic             wr_ok;
  logic             rd_go;
  logic             wr_go;

  // Write at full is legal only when a pop frees a slot.
  always_comb begin
    rd_ok = bus.rd_en & ~empty_q;
    wr_ok = bus.wr_en & (~full_q | rd_ok);
    rd_go = rd_ok & ~bus.flush;
    wr_go = wr_ok & ~bus.flush;
    cnt_n = cnt_q;
    if (bus.flush)
      cnt_n = '0;
    else
      cnt_n = cnt_q + CW'(wr_go) - CW'(rd_go);
  end

  always_ff @(posedge clk) begin
    if (wr_go && !rst)
      mem[wr_ptr] <= bus.buf_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_go)
          wr_ptr <= wr_ptr + 1'b1;
        if (rd_go) begin
          rd_ptr <= rd_ptr + 1'b1;
          buf_q  <= mem[rd_ptr];
        end
      end
      cnt_q   <= cnt_n;
      empty_q <= (cnt_n == '0);
      full_q  <= (cnt_n == CW'(DEPTH));
      ae_q    <= (cnt_n <= CW'(AE_MARGIN));
      af_q    <= (cnt_n >= CW'(DEPTH - AF_MARGIN));
      if (bus.flush) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q | (bus.wr_en & ~wr_ok);
        unf_q <= unf_q | (bus.rd_en & empty_q);
      end
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.buf_out = empty_q ? '0 : mem[rd_ptr];
    end else begin : g_std
      assign bus.buf_out = buf_q;
    end
  endgenerate

  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.counter      = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances
// driven in lockstep against a queue-based reference.
module tb_sync_fifo_param;
  localparam int W   = 8;
  localparam int D   = 64;
  localparam int AFM = 4;
  localparam int AEM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) f0 ();
  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) f1 ();

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_MARGIN(AFM),
    .AE_MARGIN(AEM), .FWFT(1'b0)
  ) u0 (.clk(clk), .rst(rst), .bus(f0));

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_MARGIN(AFM),
    .AE_MARGIN(AEM), .FWFT(1'b1)
  ) u1 (.clk(clk), .rst(rst), .bus(f1));

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] mbuf = '0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit w, input bit r,
                       input logic [W-1:0] d,
                       input bit fl, input bit rs);
    bit rok;
    bit wok;
    if (rs) begin
      q.delete();
      mbuf  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rok = r && (q.size() > 0);
      wok = w && ((q.size() < D) || rok);
      if (r && q.size() == 0) m_unf = 1'b1;
      if (w && !wok) m_ovf = 1'b1;
      if (rok) mbuf = q.pop_front();
      if (wok) q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [31:0] head;
    n = q.size();
    head = (n > 0) ? 32'(q[0]) : 32'h0;
    chk({tag, ":cnt0"}, 32'(f0.counter), n);
    chk({tag, ":cnt1"}, 32'(f1.counter), n);
    chk({tag, ":empty"}, 32'(f0.empty), 32'(n == 0));
    chk({tag, ":full"}, 32'(f0.full), 32'(n == D));
    chk({tag, ":ae"}, 32'(f0.almost_empty), 32'(n <= AEM));
    chk({tag, ":af"}, 32'(f0.almost_full), 32'(n >= D - AFM));
    chk({tag, ":ovf"}, 32'(f0.overflow), 32'(m_ovf));
    chk({tag, ":unf"}, 32'(f0.underflow), 32'(m_unf));
    chk({tag, ":empty1"}, 32'(f1.empty), 32'(n == 0));
    chk({tag, ":ovf1"}, 32'(f1.overflow), 32'(m_ovf));
    chk({tag, ":unf1"}, 32'(f1.underflow), 32'(m_unf));
    chk({tag, ":dout0"}, 32'(f0.buf_out), 32'(mbuf));
    chk({tag, ":dout1"}, 32'(f1.buf_out), head);
  endtask

  task automatic step(input bit w, input bit r,
                      input logic [W-1:0] d,
                      input bit fl, input bit rs,
                      input string tag);
    f0.wr_en = w;  f1.wr_en = w;
    f0.rd_en = r;  f1.rd_en = r;
    f0.buf_in = d; f1.buf_in = d;
    f0.flush = fl; f1.flush = fl;
    rst = rs;
    @(posedge clk);
    model(w, r, d, fl, rs);
    #1;
    check_all(tag);
  endtask

  initial begin
    f0.wr_en = 0; f1.wr_en = 0;
    f0.rd_en = 0; f1.rd_en = 0;
    f0.buf_in = '0; f1.buf_in = '0;
    f0.flush = 0; f1.flush = 0;

    step(0, 0, 8'h00, 0, 1, "rst_a");
    step(0, 0, 8'h00, 0, 1, "rst_b");
    step(0, 0, 8'h00, 0, 0, "idle");

    for (int i = 0; i < D; i++)
      step(1, 0, 8'(i), 0, 0, "fill");
    chk("full_after_64", 32'(f0.full), 32'd1);
    step(1, 0, 8'hAA, 0, 0, "ovf_write");
    chk("ovf_sticky", 32'(f0.overflow), 32'd1);
    for (int i = 0; i < D; i++) begin
      step(0, 1, 8'h00, 0, 0, "drain");
      chk("drain_order", 32'(f0.buf_out), i);
    end

    step(0, 1, 8'h00, 0, 0, "underflow");
    chk("unf_set", 32'(f0.underflow), 32'd1);
    step(0, 0, 8'h00, 1, 0, "flush_clr");
    chk("unf_clr", 32'(f0.underflow), 32'd0);

    for (int i = 0; i < D; i++)
      step(1, 0, 8'(8'h80 + i), 0, 0, "refill");
    step(1, 1, 8'h55, 0, 0, "full_rw");
    chk("full_rw_ovf", 32'(f0.overflow), 32'd0);
    chk("full_rw_cnt", 32'(f0.counter), D);
    for (int i = 0; i < D; i++)
      step(0, 1, 8'h00, 0, 0, "drain55");
    chk("last_is_55", 32'(f0.buf_out), 32'h55);

    for (int i = 0; i < 100; i++) begin
      step(1, 0, 8'(i), 0, 0, "wrap_w");
      step(0, 1, 8'h00, 0, 0, "wrap_r");
      chk("wrap_data", 32'(f0.buf_out), 32'(8'(i)));
    end

    step(0, 0, 8'h00, 1, 0, "pre_fwft");
    step(1, 0, 8'h12, 0, 0, "fwft_w1");
    chk("fwft_head", 32'(f1.buf_out), 32'h12);
    step(1, 0, 8'h34, 0, 0, "fwft_w2");
    step(0, 1, 8'h00, 0, 0, "fwft_r1");
    chk("fwft_next", 32'(f1.buf_out), 32'h34);
    step(0, 1, 8'h00, 0, 0, "fwft_r2");
    chk("fwft_empty", 32'(f1.buf_out), 32'h0);
    for (int i = 0; i < 10; i++)
      step(1, 0, 8'(8'hC0 + i), 0, 0, "pre_flush");
    step(1, 0, 8'hEE, 1, 0, "flush_wr");
    chk("flush_cnt", 32'(f0.counter), 32'd0);

    for (int i = 0; i < 10; i++)
      step(1, 0, 8'(i), 0, 0, "pre_rst");
    step(0, 0, 8'h00, 0, 1, "mid_rst");

    for (int i = 0; i < 3000; i++) begin
      bit w;
      bit r;
      bit fl;
      bit rs;
      int bias;
      bias = (i / 500) % 2;
      w  = ($urandom_range(99) < (bias ? 75 : 35));
      r  = ($urandom_range(99) < (bias ? 35 : 75));
      fl = ($urandom_range(199) == 0);
      rs = ($urandom_range(499) == 0);
      step(w, r, 8'($urandom), fl, rs, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
